nmea_rmc_parser: RTL and testbench

Byte-stream consumer placed directly downstream of the GPS UART receiver. It takes received bytes on a valid strobe and parses NMEA-0183 RMC sentences (any talker: $GPRMC, $GNRMC, ...). It verifies the XOR checksum and then atomically publishes UTC time, fix status, latitude and longitude as BCD digits to the display/logic stages.

---
 rtl/nmea_rmc_parser.sv | 254 +++++++++++++++++++++++++
 tb/tb_nmea_rmc_parser.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/nmea_rmc_parser.sv
// nmea_rmc_parser: NMEA-0183 RMC sentence parser with XOR checksum check.
// Publishes UTC time, fix status and position as BCD on a good sentence.
module nmea_rmc_parser #(
    parameter int MAX_LEN     = 82,
    parameter int FRAC_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [23:0]               utc_bcd,
    output logic                      fix_valid,
    output logic [16+4*FRAC_DIGITS-1:0] lat_bcd,
    output logic                      lat_south,
    output logic [20+4*FRAC_DIGITS-1:0] lon_bcd,
    output logic                      lon_west,
    output logic                      fix_strobe,
    output logic                      chk_err
);

    localparam int FW = 4 * FRAC_DIGITS;
    localparam int CW = $clog2(MAX_LEN + 2);
    localparam logic [CW-1:0] MAXC = CW'(MAX_LEN);
    localparam logic [7:0] FW8 = 8'(FRAC_DIGITS);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FIELDS,
        CHK_HI,
        CHK_LO
    } state_t;

    state_t state, state_n;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    xsum;
    logic [3:0]    fld;
    logic [7:0]    dcnt;
    logic          frac;
    logic [3:0]    chk_hi;

    logic [23:0]   sh_utc;
    logic          sh_fix;
    logic [15:0]   sh_lat_int;
    logic [FW-1:0] sh_lat_frac;
    logic          sh_south;
    logic [19:0]   sh_lon_int;
    logic [FW-1:0] sh_lon_frac;
    logic          sh_west;

    logic          start;
    logic          commit_ok;
    logic          commit_bad;
    logic          is_digit;
    logic          is_hex;
    logic [3:0]    hex_val;
    logic          is_eol;
    logic          hdr_ok;
    logic [3:0]    dig;

    assign cnt_inc  = cnt + 1'b1;
    assign dig      = rx_data[3:0];
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_eol   = (rx_data == 8'h0D) || (rx_data == 8'h0A);

    // Hex digit decode, both letter cases
    always_comb begin
        is_hex  = 1'b0;
        hex_val = 4'd0;
        if (is_digit) begin
            is_hex  = 1'b1;
            hex_val = rx_data[3:0];
        end else if (((rx_data >= 8'h41) && (rx_data <= 8'h46)) ||
                     ((rx_data >= 8'h61) && (rx_data <= 8'h66))) begin
            is_hex  = 1'b1;
            hex_val = rx_data[3:0] + 4'd9;
        end
    end

    // Sentence id must be "RMC" at byte positions 4..6 (talker ignored)
    always_comb begin
        hdr_ok = 1'b1;
        if (cnt_inc == CW'(4)) hdr_ok = (rx_data == 8'h52);
        if (cnt_inc == CW'(5)) hdr_ok = (rx_data == 8'h4D);
        if (cnt_inc == CW'(6)) hdr_ok = (rx_data == 8'h43);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Next state and commit decisions
    always_comb begin
        state_n    = state;
        start      = 1'b0;
        commit_ok  = 1'b0;
        commit_bad = 1'b0;
        if (rx_valid) begin
            if (rx_data == 8'h24) begin
                state_n = HDR;
                start   = 1'b1;
            end else if ((state != IDLE) && (cnt_inc > MAXC)) begin
                state_n = IDLE;
            end else begin
                unique case (state)
                    IDLE: state_n = IDLE;
                    HDR: begin
                        if (is_eol || !hdr_ok)
                            state_n = IDLE;
                        else if (cnt_inc == CW'(7))
                            state_n = (rx_data == 8'h2C) ? FIELDS : IDLE;
                    end
                    FIELDS: begin
                        if (is_eol)
                            state_n = IDLE;
                        else if (rx_data == 8'h2A)
                            state_n = CHK_HI;
                    end
                    CHK_HI: begin
                        if (is_hex) begin
                            state_n = CHK_LO;
                        end else begin
                            state_n    = IDLE;
                            commit_bad = 1'b1;
                        end
                    end
                    CHK_LO: begin
                        state_n = IDLE;
                        if (is_hex && ({chk_hi, hex_val} == xsum))
                            commit_ok = 1'b1;
                        else
                            commit_bad = 1'b1;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    // Parse datapath: counters, checksum, shadow fields, published outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            xsum        <= '0;
            fld         <= '0;
            dcnt        <= '0;
            frac        <= 1'b0;
            chk_hi      <= '0;
            sh_utc      <= '0;
            sh_fix      <= 1'b0;
            sh_lat_int  <= '0;
            sh_lat_frac <= '0;
            sh_south    <= 1'b0;
            sh_lon_int  <= '0;
            sh_lon_frac <= '0;
            sh_west     <= 1'b0;
            utc_bcd     <= '0;
            fix_valid   <= 1'b0;
            lat_bcd     <= '0;
            lat_south   <= 1'b0;
            lon_bcd     <= '0;
            lon_west    <= 1'b0;
            fix_strobe  <= 1'b0;
            chk_err     <= 1'b0;
        end else begin
            fix_strobe <= commit_ok;
            chk_err    <= commit_bad;
            if (commit_ok) begin
                utc_bcd   <= sh_utc;
                fix_valid <= sh_fix;
                lat_bcd   <= {sh_lat_int, sh_lat_frac};
                lat_south <= sh_south;
                lon_bcd   <= {sh_lon_int, sh_lon_frac};
                lon_west  <= sh_west;
            end
            if (rx_valid) begin
                if (start) begin
                    cnt         <= CW'(1);
                    xsum        <= '0;
                    fld         <= '0;
                    dcnt        <= '0;
                    frac        <= 1'b0;
                    sh_utc      <= '0;
                    sh_fix      <= 1'b0;
                    sh_lat_int  <= '0;
                    sh_lat_frac <= '0;
                    sh_south    <= 1'b0;
                    sh_lon_int  <= '0;
                    sh_lon_frac <= '0;
                    sh_west     <= 1'b0;
                end else if (state != IDLE) begin
                    cnt <= cnt_inc;
                    if (((state == HDR) || (state == FIELDS)) &&
                        (rx_data != 8'h2A))
                        xsum <= xsum ^ rx_data;
                    if (state == CHK_HI)
                        chk_hi <= hex_val;
                    if ((state == HDR) && (state_n == FIELDS)) begin
                        fld  <= 4'd1;
                        dcnt <= '0;
                        frac <= 1'b0;
                    end
                    if ((state == FIELDS) && (state_n == FIELDS)) begin
                        if (rx_data == 8'h2C) begin
                            if (fld != 4'hF) fld <= fld + 4'd1;
                            dcnt <= '0;
                            frac <= 1'b0;
                        end else if (rx_data == 8'h2E) begin
                            frac <= 1'b1;
                        end else begin
                            unique case (1'b1)
                                (fld == 4'd1): begin
                                    if (is_digit && !frac && (dcnt < 8'd6)) begin
                                        sh_utc <= {sh_utc[19:0], dig};
                                        dcnt   <= dcnt + 8'd1;
                                    end
                                end
                                (fld == 4'd2): sh_fix <= (rx_data == 8'h41);
                                (fld == 4'd3): begin
                                    if (is_digit && !frac) begin
                                        sh_lat_int <= {sh_lat_int[11:0], dig};
                                    end else if (is_digit && (dcnt < FW8)) begin
                                        for (int i = 0; i < FRAC_DIGITS; i++)
                                            if (dcnt == 8'(i))
                                                sh_lat_frac[FW-4-4*i +: 4] <= dig;
                                        dcnt <= dcnt + 8'd1;
                                    end
                                end
                                (fld == 4'd4): sh_south <= (rx_data == 8'h53);
                                (fld == 4'd5): begin
                                    if (is_digit && !frac) begin
                                        sh_lon_int <= {sh_lon_int[15:0], dig};
                                    end else if (is_digit && (dcnt < FW8)) begin
                                        for (int i = 0; i < FRAC_DIGITS; i++)
                                            if (dcnt == 8'(i))
                                                sh_lon_frac[FW-4-4*i +: 4] <= dig;
                                        dcnt <= dcnt + 8'd1;
                                    end
                                end
                                (fld == 4'd6): sh_west <= (rx_data == 8'h57);
                                default: ;
                            endcase
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_nmea_rmc_parser.sv
// tb_nmea_rmc_parser: directed sentences with hand-computed field values.
// Covers commit, bad checksum, restarts, length limit and async reset.
module tb_nmea_rmc_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [23:0] utc_bcd;
    logic        fix_valid;
    logic [31:0] lat_bcd;
    logic        lat_south;
    logic [35:0] lon_bcd;
    logic        lon_west;
    logic        fix_strobe;
    logic        chk_err;

    int total  = 0;
    int passed = 0;
    int n_fix  = 0;
    int n_err  = 0;
    int n_both = 0;
    int f0, e0;

    nmea_rmc_parser #(.MAX_LEN(82), .FRAC_DIGITS(4)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .utc_bcd(utc_bcd), .fix_valid(fix_valid),
        .lat_bcd(lat_bcd), .lat_south(lat_south),
        .lon_bcd(lon_bcd), .lon_west(lon_west),
        .fix_strobe(fix_strobe), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fix_strobe) n_fix++;
        if (chk_err) n_err++;
        if (fix_strobe && chk_err) n_both++;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_data(input string tag, input logic [23:0] u,
                              input logic f, input logic [31:0] la,
                              input logic s, input logic [35:0] lo,
                              input logic w);
        check({tag, "_utc"}, 64'(utc_bcd), 64'(u));
        check({tag, "_fix"}, 64'(fix_valid), 64'(f));
        check({tag, "_lat"}, 64'(lat_bcd), 64'(la));
        check({tag, "_south"}, 64'(lat_south), 64'(s));
        check({tag, "_lon"}, 64'(lon_bcd), 64'(lo));
        check({tag, "_west"}, 64'(lon_west), 64'(w));
    endtask

    function automatic logic [7:0] nmea_xor(input string s);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < s.len(); i++) x ^= s[i];
        return x;
    endfunction

    function automatic logic [7:0] hexc(input logic [3:0] n, input bit lower);
        if (n < 4'd10) return 8'h30 + {4'd0, n};
        return (lower ? 8'h61 : 8'h41) + {4'd0, n} - 8'd10;
    endfunction

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic send_frame(input string body, input logic [7:0] cks,
                              input bit lower);
        send(8'h24);
        send_str(body);
        send(8'h2A);
        send(hexc(cks[7:4], lower));
        send(hexc(cks[3:0], lower));
    endtask

    task automatic pulse_counts(input string tag, input int fx, input int er);
        check({tag, "_nfix"}, 64'(n_fix - f0), 64'(fx));
        check({tag, "_nerr"}, 64'(n_err - e0), 64'(er));
    endtask

    string b1, b3, bg, b4, b5, bl, bo;

    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_data("reset", 24'h0, 1'b0, 32'h0, 1'b0, 36'h0, 1'b0);
        check("reset_strobe", 64'(fix_strobe), 64'd0);
        check("reset_err", 64'(chk_err), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        b1 = "GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W";
        f0 = n_fix; e0 = n_err;
        send_frame(b1, 8'h6A, 1'b0);
        check("t1_strobe_lat1", 64'(fix_strobe), 64'd1);
        check("t1_err", 64'(chk_err), 64'd0);
        send_str("\r\n");
        pulse_counts("t1", 1, 0);
        check_data("t1", 24'h123519, 1'b1, 32'h48070380, 1'b0,
                   36'h011310000, 1'b0);

        f0 = n_fix; e0 = n_err;
        send_frame(b1, 8'h6B, 1'b0);
        check("t2_err_pulse", 64'(chk_err), 64'd1);
        check("t2_strobe", 64'(fix_strobe), 64'd0);
        send_str("\r\n");
        pulse_counts("t2", 0, 1);
        check_data("t2", 24'h123519, 1'b1, 32'h48070380, 1'b0,
                   36'h011310000, 1'b0);

        b3 = "GNRMC,000001.00,V,3344.5,S,15112.25,W,,,,,";
        f0 = n_fix; e0 = n_err;
        send_frame(b3, nmea_xor(b3), 1'b1);
        send_str("\r\n");
        pulse_counts("t3", 1, 0);
        check_data("t3", 24'h000001, 1'b0, 32'h33445000, 1'b1,
                   36'h151122500, 1'b1);

        bg = "GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,";
        f0 = n_fix; e0 = n_err;
        send_frame(bg, nmea_xor(bg), 1'b0);
        send_str("\r\n");
        pulse_counts("t4_gga", 0, 0);
        check_data("t4_gga", 24'h000001, 1'b0, 32'h33445000, 1'b1,
                   36'h151122500, 1'b1);

        b4 = "GPRMC,235959,A,1234.5678,N,12345.6789,E,,,,,";
        f0 = n_fix; e0 = n_err;
        send_str("$GPRMC,0102");
        send_frame(b4, nmea_xor(b4), 1'b0);
        send_str("\r\n");
        pulse_counts("t4_restart", 1, 0);
        check_data("t4_restart", 24'h235959, 1'b1, 32'h12345678, 1'b0,
                   36'h123456789, 1'b0);

        f0 = n_fix; e0 = n_err;
        send(8'h24);
        send_str("GPRMC,");
        for (int i = 0; i < 94; i++) send(8'h39);
        send_str("\r\n");
        pulse_counts("t5_long", 0, 0);
        check_data("t5_long", 24'h235959, 1'b1, 32'h12345678, 1'b0,
                   36'h123456789, 1'b0);
        b5 = "GPRMC,101010,A,0900.25,S,00808.5,W,,";
        f0 = n_fix; e0 = n_err;
        send_frame(b5, nmea_xor(b5), 1'b0);
        send_str("\r\n");
        pulse_counts("t5_after", 1, 0);
        check_data("t5_after", 24'h101010, 1'b1, 32'h09002500, 1'b1,
                   36'h008085000, 1'b1);

        bl = "GPRMC,123519,A,4807.038,N,01131.000,E";
        while (bl.len() < 78) bl = {bl, ","};
        f0 = n_fix; e0 = n_err;
        send_frame(bl, nmea_xor(bl), 1'b0);
        check("t6_len82_strobe", 64'(fix_strobe), 64'd1);
        send_str("\r\n");
        check_data("t6_len82", 24'h123519, 1'b1, 32'h48070380, 1'b0,
                   36'h011310000, 1'b0);
        bo = "GPRMC,222222,V,1111.1111,N,22222.2222,E";
        while (bo.len() < 79) bo = {bo, ","};
        f0 = n_fix; e0 = n_err;
        send_frame(bo, nmea_xor(bo), 1'b0);
        send_str("\r\n");
        pulse_counts("t6_len83", 0, 0);
        check_data("t6_len83", 24'h123519, 1'b1, 32'h48070380, 1'b0,
                   36'h011310000, 1'b0);

        send_str("$GPRMC,1235");
        #2;
        rst = 1'b0;
        #1;
        check_data("t7_async", 24'h0, 1'b0, 32'h0, 1'b0, 36'h0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        f0 = n_fix; e0 = n_err;
        send_frame(b5, nmea_xor(b5), 1'b0);
        send_str("\r\n");
        pulse_counts("t7_after", 1, 0);
        check_data("t7_after", 24'h101010, 1'b1, 32'h09002500, 1'b1,
                   36'h008085000, 1'b1);

        check("no_overlap", 64'(n_both), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
